// File: rtl/joystick_scanner_if.sv
// joystick_scanner_if: enable/chain/result signals between the scanner and its environment
interface joystick_scanner_if #(
  parameter int W = 16
);
  logic         enable;
  logic         joy_clk;
  logic         joy_load;
  logic         joy_data;
  logic         joy_sel;
  logic [W-1:0] joy_out;
  logic         scan_done;
  modport master (
    input  enable, joy_data,
    output joy_clk, joy_load, joy_sel, joy_out, scan_done
  );
  modport slave (
    output enable, joy_data,
    input  joy_clk, joy_load, joy_sel, joy_out, scan_done
  );
endinterface

// File: rtl/joystick_scanner.sv
// joystick_scanner: scans a 74HC165 joystick chain (optionally two select phases) and debounces whole scans
module joystick_scanner #(
  parameter int NUM_PORTS      = 2,
  parameter int BITS_PER_PORT  = 8,
  parameter int SELECT_PHASES  = 1,
  parameter int CLK_DIV        = 16,
  parameter int DEBOUNCE_SCANS = 2
) (
  input  logic clk,
  input  logic reset_n,
  joystick_scanner_if.master bus
);
  localparam int NB = NUM_PORTS * BITS_PER_PORT;
  localparam int W  = NB * SELECT_PHASES;
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(NB);
  localparam int PW = $clog2(SELECT_PHASES + 1);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int IW = $clog2(W);

  typedef enum logic [2:0] {IDLE, SETTLE, LOAD, SHIFT_LO, SHIFT_HI, COMMIT} state_t;

  logic [1:0]    sync_q;
  logic          rst_n;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          sel_q, sel_d;
  logic [W-1:0]  raw_q, raw_d, prev_q, prev_d, out_q, out_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [IW-1:0] idx;
  logic          cnt_end, bit_last, phase_last, stable_full;

  // Reset asserts immediately but releases two clocks after reset_n rises
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync_q <= 2'b00;
    else sync_q <= {sync_q[0], 1'b1};
  assign rst_n = sync_q[1];

  assign cnt_end     = int'(cnt_q) == CLK_DIV - 1;
  assign bit_last    = int'(bit_q) == NB - 1;
  assign phase_last  = int'(phase_q) == SELECT_PHASES - 1;
  assign stable_full = int'(stable_q) == DEBOUNCE_SCANS;
  assign idx         = IW'(phase_q) * IW'(NB) + IW'(bit_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_end ? '0 : cnt_q + 1'b1;
    bit_d    = bit_q;
    phase_d  = phase_q;
    sel_d    = sel_q;
    raw_d    = raw_q;
    prev_d   = prev_q;
    stable_d = stable_q;
    out_d    = out_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.enable) begin
          sel_d   = 1'b1;
          bit_d   = '0;
          phase_d = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: if (cnt_end) state_d = LOAD;
      LOAD: if (cnt_end) state_d = SHIFT_LO;
      SHIFT_LO: if (cnt_end) begin
        raw_d[idx] = bus.joy_data;
        state_d    = SHIFT_HI;
      end
      SHIFT_HI: if (cnt_end) begin
        if (!bit_last) begin
          bit_d   = bit_q + 1'b1;
          state_d = SHIFT_LO;
        end else if (!phase_last) begin
          bit_d   = '0;
          phase_d = phase_q + 1'b1;
          sel_d   = 1'b0;
          state_d = SETTLE;
        end else begin
          sel_d   = 1'b1;
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        cnt_d    = '0;
        sel_d    = 1'b1;
        bit_d    = '0;
        phase_d  = '0;
        stable_d = raw_q != prev_q ? SW'(1) : stable_full ? stable_q : stable_q + 1'b1;
        prev_d   = raw_q;
        out_d    = stable_d == SW'(DEBOUNCE_SCANS) ? raw_q : out_q;
        state_d  = bus.enable ? SETTLE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      phase_q  <= '0;
      sel_q    <= 1'b1;
      raw_q    <= '1;
      prev_q   <= '1;
      stable_q <= '0;
      out_q    <= '1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      sel_q    <= sel_d;
      raw_q    <= raw_d;
      prev_q   <= prev_d;
      stable_q <= stable_d;
      out_q    <= out_d;
    end

  assign bus.joy_clk   = state_q == SHIFT_HI;
  assign bus.joy_load  = state_q != LOAD;
  assign bus.joy_sel   = sel_q;
  assign bus.joy_out   = out_q;
  assign bus.scan_done = state_q == COMMIT;
endmodule

// File: tb/tb_joystick_scanner.sv
// tb_joystick_scanner: directed table-driven checks of three scanner configurations against 74HC165 chain models
module tb_joystick_scanner;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  joystick_scanner_if #(.W(16)) if0 ();
  joystick_scanner_if #(.W(32)) if1 ();
  joystick_scanner_if #(.W(32)) if2 ();

  joystick_scanner #(.CLK_DIV(4)) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0.master));
  joystick_scanner #(.SELECT_PHASES(2), .CLK_DIV(4)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1.master));
  joystick_scanner #(.NUM_PORTS(4), .CLK_DIV(4), .DEBOUNCE_SCANS(1)) dut2 (.clk(clk), .reset_n(reset_n), .bus(if2.master));

  // Chain models: load while joy_load low, shift one bit per joy_clk rise, bit 0 is presented first
  logic [15:0] pat0, sr0, sr1;
  logic [31:0] pat2, sr2;
  logic        jc0, jc1, jc2;
  always @(posedge clk) begin
    jc0 <= if0.joy_clk;
    jc1 <= if1.joy_clk;
    jc2 <= if2.joy_clk;
    if (!if0.joy_load) sr0 <= pat0;
    else if (if0.joy_clk && !jc0) sr0 <= {1'b1, sr0[15:1]};
    if (!if1.joy_load) sr1 <= if1.joy_sel ? 16'h0F0F : 16'hF0F0;
    else if (if1.joy_clk && !jc1) sr1 <= {1'b1, sr1[15:1]};
    if (!if2.joy_load) sr2 <= pat2;
    else if (if2.joy_clk && !jc2) sr2 <= {1'b1, sr2[31:1]};
  end
  assign if0.joy_data = sr0[0];
  assign if1.joy_data = sr1[0];
  assign if2.joy_data = sr2[0];

  logic [2:0] dn;
  assign dn = {if2.scan_done, if1.scan_done, if0.scan_done};

  typedef struct {
    logic [31:0] pat;
    logic [31:0] exp;
  } vec_t;
  vec_t v0[13];
  vec_t v2[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int w, output int t);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (dn[w]) begin
        t = cyc;
        return;
      end
    end
    n_chk++;
    n_err++;
    t = cyc;
    $display("FAIL wait_done%0d: no scan_done within 1000 cycles, expected a pulse", w);
  endtask

  initial begin
    int t, tp, r, np, lo;
    logic pj, got;
    v0 = '{'{32'h3CA5, 32'hFFFF}, '{32'hC35A, 32'hFFFF}, '{32'h3CA5, 32'hFFFF},
           '{32'hC35A, 32'hFFFF}, '{32'h3CA5, 32'hFFFF}, '{32'h3CA5, 32'h3CA5},
           '{32'h3CA5, 32'h3CA5}, '{32'h1234, 32'h3CA5}, '{32'h1234, 32'h1234},
           '{32'hFFFF, 32'h1234}, '{32'h0000, 32'h1234}, '{32'hFFFF, 32'h1234},
           '{32'hFFFF, 32'hFFFF}};
    v2 = '{'{32'h12345678, 32'h12345678}, '{32'h9ABCDEF0, 32'h9ABCDEF0},
           '{32'hFFFF0000, 32'hFFFF0000}, '{32'h00000001, 32'h00000001}};
    if0.enable = 1'b0;
    if1.enable = 1'b0;
    if2.enable = 1'b0;
    pat0 = v0[0].pat[15:0];
    pat2 = v2[0].pat;
    repeat (3) @(negedge clk);
    check("rst_clk", 32'(if0.joy_clk), 0);
    check("rst_load", 32'(if0.joy_load), 1);
    check("rst_sel", 32'(if0.joy_sel), 1);
    check("rst_done", 32'(if0.scan_done), 0);
    check("rst_out0", 32'(if0.joy_out), 32'hFFFF);
    check("rst_out1", if1.joy_out, 32'hFFFFFFFF);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_load", 32'(if0.joy_load), 1);
    check("idle_clk", 32'(if0.joy_clk), 0);
    // Debounce table incl. toggling patterns that must never leave all ones
    if0.enable = 1'b1;
    tp = 0;
    for (int i = 0; i < 13; i++) begin
      wait_done(0, t);
      if (i > 0) check("period0", t - tp, 137);
      tp = t;
      if (i < 12) pat0 = v0[i + 1].pat[15:0];
      @(negedge clk);
      check($sformatf("tbl0[%0d]", i), 32'(if0.joy_out), v0[i].exp);
    end
    check("sel_single", 32'(if0.joy_sel), 1);
    // Drop enable mid-scan, after five shift clocks
    r = 0;
    pj = 1'b0;
    for (int i = 0; i < 500 && r < 5; i++) begin
      @(negedge clk);
      if (if0.joy_clk && !pj) r++;
      pj = if0.joy_clk;
    end
    if0.enable = 1'b0;
    np = 0;
    repeat (400) begin
      @(negedge clk);
      np += int'(dn[0]);
    end
    check("drop_pulses", np, 1);
    check("drop_clk", 32'(if0.joy_clk), 0);
    check("drop_load", 32'(if0.joy_load), 1);
    // Reset in SHIFT_HI discards debounce history
    pat0 = 16'h3CA5;
    if0.enable = 1'b1;
    wait_done(0, t);
    @(negedge clk);
    check("pre_rst1", 32'(if0.joy_out), 32'hFFFF);
    wait_done(0, t);
    @(negedge clk);
    check("pre_rst2", 32'(if0.joy_out), 32'h3CA5);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = if0.joy_clk;
    end
    check("found_shift_hi", 32'(got), 1);
    reset_n = 1'b0;
    #1;
    check("mid_clk", 32'(if0.joy_clk), 0);
    check("mid_load", 32'(if0.joy_load), 1);
    check("mid_sel", 32'(if0.joy_sel), 1);
    check("mid_done", 32'(if0.scan_done), 0);
    check("mid_out", 32'(if0.joy_out), 32'hFFFF);
    @(negedge clk);
    reset_n = 1'b1;
    wait_done(0, t);
    @(negedge clk);
    check("post_rst1", 32'(if0.joy_out), 32'hFFFF);
    wait_done(0, t);
    @(negedge clk);
    check("post_rst2", 32'(if0.joy_out), 32'h3CA5);
    if0.enable = 1'b0;
    // Two-phase scan
    if1.enable = 1'b1;
    wait_done(1, tp);
    lo = 0;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (dn[1]) got = 1'b1;
      else lo += int'(!if1.joy_sel);
    end
    t = cyc;
    check("sp2_done", 32'(got), 1);
    check("sp2_period", t - tp, 273);
    check("sp2_sel_low", lo, 136);
    check("sp2_sel_commit", 32'(if1.joy_sel), 1);
    @(negedge clk);
    check("sp2_out", if1.joy_out, 32'hF0F00F0F);
    if1.enable = 1'b0;
    // Four ports, no debounce
    if2.enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_done(2, t);
      if (i > 0) check("period2", t - tp, 265);
      tp = t;
      if (i < 3) pat2 = v2[i + 1].pat;
      @(negedge clk);
      check($sformatf("tbl2[%0d]", i), if2.joy_out, v2[i].exp);
    end
    if2.enable = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/joystick_scanner.md
JOYSTICK_SCANNER -- requirements
Module: joystick_scanner

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of joystick ports daisy-chained on one serial shift chain (range 1-4).
REQ-002 Parameter BITS_PER_PORT, default 8: shift-register bits per port per select phase (range 4-16).
REQ-003 Parameter SELECT_PHASES, default 1: 1 = plain DB9 scan; 2 = two-phase scan with joy_sel toggled between phases (Mega Drive style pads).
REQ-004 Parameter CLK_DIV, default 16: clk cycles per half period of joy_clk, per load pulse and per select-settle interval (min 2).
REQ-005 Parameter DEBOUNCE_SCANS, default 2: consecutive identical complete scans required before joy_out updates (min 1).
REQ-006 Localparam W = NUM_PORTS*BITS_PER_PORT*SELECT_PHASES: raw scan width.
REQ-007 clk  in  1  system clock; all logic on the rising edge.
REQ-008 reset_n  in  1  asynchronous active-low reset; assertion acts immediately, deassertion is synchronised internally to clk.
REQ-009 enable  in  1  high = scan continuously; low = return to IDLE after the current scan.
REQ-010 joy_clk  out  1  shift clock to the external 74HC165 chain.
REQ-011 joy_load  out  1  active-low parallel load to the chain.
REQ-012 joy_data  in  1  serial data from the chain; sampled directly with no additional synchronising stage.
REQ-013 joy_sel  out  1  pad select line (joyP7_o); held at 1 when SELECT_PHASES = 1.
REQ-014 joy_out  out  W  debounced active-low button state.
REQ-015 scan_done  out  1  one-cycle pulse at the end of every complete scan.

Function
REQ-016 The FSM states SHALL be IDLE, SETTLE, LOAD, SHIFT_LO, SHIFT_HI and COMMIT.
REQ-017 IDLE: if enable = 1, the FSM SHALL set joy_sel = 1, clear the phase and bit counters, and go to SETTLE.
REQ-018 SETTLE SHALL last CLK_DIV cycles with joy_load = 1 and joy_clk = 0, then go to LOAD.
REQ-019 LOAD SHALL drive joy_load = 0 for CLK_DIV cycles, then joy_load = 1 and go to SHIFT_LO.
REQ-020 SHIFT_LO SHALL hold joy_clk = 0 for CLK_DIV cycles and sample joy_data into the raw register on its last cycle, then go to SHIFT_HI.
REQ-021 SHIFT_HI SHALL hold joy_clk = 1 for CLK_DIV cycles, then go to SHIFT_LO, or end the phase once NUM_PORTS*BITS_PER_PORT bits have been sampled.
REQ-022 The k-th sampled bit (k = 0 first) of phase p SHALL be stored at raw index p*NUM_PORTS*BITS_PER_PORT + k.
REQ-023 At phase end, if p < SELECT_PHASES-1 the FSM SHALL set joy_sel = 0, increment p and go to SETTLE; otherwise it SHALL go to COMMIT.
REQ-024 COMMIT SHALL last 1 cycle, pulse scan_done, and restore joy_sel = 1.
REQ-025 In COMMIT, if raw == the previous raw, stable_cnt SHALL increment, saturating at DEBOUNCE_SCANS; otherwise stable_cnt = 1 and previous raw <= raw.
REQ-026 joy_out SHALL load raw in the COMMIT cycle in which stable_cnt reaches or already holds DEBOUNCE_SCANS; DEBOUNCE_SCANS = 1 means every scan updates.
REQ-027 After COMMIT the FSM SHALL go to SETTLE if enable = 1, else to IDLE.
REQ-028 enable falling mid-scan SHALL NOT abort the scan; the scan completes, including COMMIT.
REQ-029 Scan length SHALL be exactly SELECT_PHASES*(2*CLK_DIV + NUM_PORTS*BITS_PER_PORT*2*CLK_DIV) + 1 cycles.
REQ-030 Counters SHALL be sized from parameters with $clog2; no width truncation at the maximum parameter values.

Reset
REQ-031 On reset: state = IDLE, joy_clk = 0, joy_load = 1, joy_sel = 1, scan_done = 0, joy_out = all ones, raw and previous raw = all ones, stable_cnt = 0.
REQ-032 Reset asserted mid-scan SHALL return all outputs to their reset values asynchronously; a partial scan SHALL never reach joy_out.

Verification
REQ-033 Defaults except CLK_DIV = 4; constant chain pattern 0xA5, 0x3C: scan_done period = 137 cycles; joy_out = 16'h3CA5-ordered per REQ-022 only after the 2nd scan_done, all ones after the 1st.
REQ-034 Pattern toggles every scan: joy_out never leaves all ones.
REQ-035 SELECT_PHASES = 2, phase patterns 0x0F / 0xF0 per port: joy_sel low exactly during phase 1; raw upper half = phase-1 data; scan length = 273 cycles.
REQ-036 enable dropped at bit 5 of the scan: scan completes, scan_done pulses once, FSM idles with joy_clk = 0 and joy_load = 1.
REQ-037 reset_n pulsed low during SHIFT_HI: joy_clk = 0 and joy_load = 1 in the same cycle; joy_out = all ones; first full debounce is required again.
REQ-038 DEBOUNCE_SCANS = 1, NUM_PORTS = 4: joy_out follows every scan; 32-bit ordering is checked against the chain model.
